mux8_rr_sched: RTL and testbench

Round-robin scheduler that shares the 8:1 multiplexer's single output line among eight requesters. It samples a request vector, grants exactly one source at a time, and drives the mux select lines (A, B, C) plus a one-hot grant. It also presents the selected data bit. It sits directly in front of the 8:1 mux in the datapath, and replaces hand-driven select stimulus with a fair, bounded-hold time-division scheme.

---
 rtl/mux8_rr_sched.sv | 109 ++++++++++
 tb/tb_mux8_rr_sched.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux8_rr_sched.sv
// Round-robin scheduler that time-shares an 8:1 mux among eight requesters,
// driving the select lines, a one-hot grant and the selected data bit.
module mux8_rr_sched #(
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       en_i,
    input  logic [7:0] req_i,
    input  logic [7:0] d_i,
    output logic [7:0] gnt_o,
    output logic [2:0] sel_o,
    output logic       busy_o,
    output logic       p_o
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [2:0]       own_q, own_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       gnt_q, gnt_d;
    logic [2:0]       sel_q, sel_d;
    logic             busy_q, busy_d;

    logic [2:0]       pickIdx;
    logic             pickFound;
    logic [2:0]       scanIdx;

    // First requester at or after the pointer, wrapping modulo 8.
    always_comb begin
        pickIdx   = ptr_q;
        pickFound = 1'b0;
        scanIdx   = 3'd0;
        for (int k = 0; k < 8; k++) begin
            scanIdx = ptr_q + 3'(k);
            if (!pickFound && req_i[scanIdx]) begin
                pickIdx   = scanIdx;
                pickFound = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (en_i && pickFound) begin
                    own_d   = pickIdx;
                    sel_d   = pickIdx;
                    gnt_d   = 8'b1 << pickIdx;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = GRANT;
                end else begin
                    gnt_d  = 8'h00;
                    sel_d  = 3'b000;
                    busy_d = 1'b0;
                end
            end
            GRANT: begin
                // Sel is left alone on release; p is already gated by busy.
                if (!req_i[own_q] || (cnt_q == CNT_W'(MAX_HOLD - 1))) begin
                    gnt_d   = 8'h00;
                    busy_d  = 1'b0;
                    ptr_d   = own_q + 3'd1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            own_q   <= 3'd0;
            cnt_q   <= '0;
            gnt_q   <= 8'h00;
            sel_q   <= 3'b000;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt_o  = gnt_q;
    assign sel_o  = sel_q;
    assign busy_o = busy_q;
    assign p_o    = busy_q ? d_i[sel_q] : 1'b0;

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Randomized and directed bench for mux8_rr_sched, checked against a
// grant-level model of the round-robin and hold-limit rules.
module tb_mux8_rr_sched;

    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic [7:0] req = 8'h00;
    logic [7:0] d = 8'h00;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       p;

    int errors = 0;
    int checks = 0;

    // Model state: who holds the line, for how many cycles so far, next start point.
    logic mBusy = 1'b0;
    int   mOwn  = 0;
    int   mHeld = 0;
    int   mPtr  = 0;
    int   mSel  = 0;

    mux8_rr_sched #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .en_i    (en),
        .req_i   (req),
        .d_i     (d),
        .gnt_o   (gnt),
        .sel_o   (sel),
        .busy_o  (busy),
        .p_o     (p)
    );

    always #5 clk = ~clk;

    function automatic int pickNext(logic [7:0] r, int ptr);
        for (int k = 0; k < 8; k++) begin
            if (r[(ptr + k) % 8]) return (ptr + k) % 8;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            mBusy <= 1'b0;
            mPtr  <= 0;
            mSel  <= 0;
            mHeld <= 0;
        end else if (!mBusy) begin
            if (en && pickNext(req, mPtr) >= 0) begin
                mOwn  <= pickNext(req, mPtr);
                mSel  <= pickNext(req, mPtr);
                mBusy <= 1'b1;
                mHeld <= 1;
            end else begin
                mSel <= 0;
            end
        end else if (!req[mOwn] || mHeld == MAX_HOLD) begin
            mBusy <= 1'b0;
            mPtr  <= (mOwn + 1) % 8;
        end else begin
            mHeld <= mHeld + 1;
        end
    end

    task automatic doReset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] expGnt;
        req = 8'hFF; en = 1'b1; d = 8'hFF; rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (gnt !== 8'h00) begin errors++; $display("[TB] FAIL reset_gnt: got %h expected 00", gnt); end
        checks++; if (sel !== 3'd0) begin errors++; $display("[TB] FAIL reset_sel: got %0d expected 0", sel); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (p !== 1'b0) begin errors++; $display("[TB] FAIL reset_p: got %b expected 0", p); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (gnt !== 8'h01) begin errors++; $display("[TB] FAIL reset_first_grant: got %h expected 01", gnt); end
        expGnt = mBusy ? 8'(1 << mOwn) : 8'h00;
        checks++; if (gnt !== expGnt) begin errors++; $display("[TB] FAIL reset_model_gnt: got %h expected %h", gnt, expGnt); end
    endtask

    task automatic test_round_robin();
        logic [7:0] expGnt;
        logic       prevBusy = 1'b0;
        int         run = 0;
        int         idleRun = 0;
        int         nGrants = 0;
        req = 8'hFF; en = 1'b1;
        doReset();
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            expGnt = mBusy ? 8'(1 << mOwn) : 8'h00;
            checks++; if (gnt !== expGnt) begin errors++; $display("[TB] FAIL rr_gnt: got %h expected %h", gnt, expGnt); end
            checks++; if (busy !== mBusy) begin errors++; $display("[TB] FAIL rr_busy: got %b expected %b", busy, mBusy); end
            if (busy && !prevBusy) begin
                checks++; if (sel !== 3'(nGrants % 8)) begin errors++; $display("[TB] FAIL rr_order: got %0d expected %0d", sel, nGrants % 8); end
                if (nGrants > 0) begin
                    checks++; if (idleRun != 1) begin errors++; $display("[TB] FAIL rr_idle_gap: got %0d expected 1", idleRun); end
                end
                nGrants++;
                idleRun = 0;
            end
            if (busy) run++;
            else begin
                idleRun++;
                if (prevBusy) begin
                    checks++; if (run != MAX_HOLD) begin errors++; $display("[TB] FAIL rr_hold_len: got %0d expected %0d", run, MAX_HOLD); end
                    run = 0;
                end
            end
            prevBusy = busy;
        end
        checks++; if (nGrants != 9) begin errors++; $display("[TB] FAIL rr_grant_count: got %0d expected 9", nGrants); end
    endtask

    task automatic test_early_release();
        req = 8'b1001_0000; en = 1'b1;
        doReset();
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            checks++; if (busy !== mBusy) begin errors++; $display("[TB] FAIL er_busy c%0d: got %b expected %b", c, busy, mBusy); end
            if (c == 0) begin
                checks++; if (gnt !== 8'h10) begin errors++; $display("[TB] FAIL er_first: got %h expected 10", gnt); end
            end
            if (c == 1) req = 8'b1000_0000;
            if (c == 2) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL er_release: got %b expected 0", busy); end
                req = 8'b1001_0000;
            end
            if (c == 3) begin
                checks++; if (gnt !== 8'h80) begin errors++; $display("[TB] FAIL er_skip_to_7: got %h expected 80", gnt); end
            end
            if (c == 8) begin
                checks++; if (gnt !== 8'h10) begin errors++; $display("[TB] FAIL er_wrap_to_4: got %h expected 10", gnt); end
            end
        end
    endtask

    task automatic test_datapath();
        req = 8'h40; en = 1'b1; d = 8'b0100_0000;
        doReset();
        @(negedge clk);
        checks++; if (sel !== 3'd6) begin errors++; $display("[TB] FAIL dp_sel: got %0d expected 6", sel); end
        checks++; if (p !== 1'b1) begin errors++; $display("[TB] FAIL dp_p_high: got %b expected 1", p); end
        d[5] = ~d[5]; d[7] = ~d[7];
        #1;
        checks++; if (p !== 1'b1) begin errors++; $display("[TB] FAIL dp_neighbours: got %b expected 1", p); end
        d[6] = 1'b0;
        #1;
        checks++; if (p !== 1'b0) begin errors++; $display("[TB] FAIL dp_p_low: got %b expected 0", p); end
    endtask

    task automatic test_enable();
        int busyLen = 0;
        req = 8'h01; en = 1'b0;
        doReset();
        repeat (3) begin
            @(negedge clk);
            checks++; if (busy !== 1'b0 || gnt !== 8'h00) begin errors++; $display("[TB] FAIL en_blocked: got busy=%b gnt=%h expected busy=0 gnt=00", busy, gnt); end
        end
        en = 1'b1;
        @(negedge clk);
        checks++; if (gnt !== 8'h01) begin errors++; $display("[TB] FAIL en_grant: got %h expected 01", gnt); end
        en = 1'b0;
        busyLen = busy ? 1 : 0;
        repeat (6) begin
            @(negedge clk);
            if (busy) busyLen++;
        end
        checks++; if (busyLen != MAX_HOLD) begin errors++; $display("[TB] FAIL en_hold_len: got %0d expected %0d", busyLen, MAX_HOLD); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL en_stay_idle: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid_grant();
        req = 8'h20; en = 1'b1;
        doReset();
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (c == 4) req = 8'h08;
            if (c == 5) begin
                checks++; if (gnt !== 8'h08) begin errors++; $display("[TB] FAIL rm_grant3: got %h expected 08", gnt); end
            end
            if (c == 6) begin
                rst_n = 1'b0;
                req = 8'hC8;
            end
            if (c == 7) begin
                checks++; if (gnt !== 8'h00 || busy !== 1'b0) begin errors++; $display("[TB] FAIL rm_reset: got gnt=%h busy=%b expected gnt=00 busy=0", gnt, busy); end
                rst_n = 1'b1;
            end
            if (c == 8) begin
                checks++; if (gnt !== 8'h08) begin errors++; $display("[TB] FAIL rm_ptr_cleared: got %h expected 08", gnt); end
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] expGnt;
        logic       expP;
        req = 8'h00; en = 1'b1;
        doReset();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            expGnt = mBusy ? 8'(1 << mOwn) : 8'h00;
            expP   = mBusy ? d[mSel] : 1'b0;
            checks++; if (gnt !== expGnt) begin errors++; $display("[TB] FAIL rnd_gnt c%0d: got %h expected %h", c, gnt, expGnt); end
            checks++; if (busy !== mBusy) begin errors++; $display("[TB] FAIL rnd_busy c%0d: got %b expected %b", c, busy, mBusy); end
            if (mBusy) begin
                checks++; if (sel !== 3'(mSel)) begin errors++; $display("[TB] FAIL rnd_sel c%0d: got %0d expected %0d", c, sel, mSel); end
            end
            checks++; if (p !== expP) begin errors++; $display("[TB] FAIL rnd_p c%0d: got %b expected %b", c, p, expP); end
            if ($urandom_range(0, 3) == 0) req = 8'($urandom) & 8'($urandom);
            en    = ($urandom_range(0, 4) != 0);
            rst_n = ($urandom_range(0, 59) != 0);
            d     = 8'($urandom);
            #1;
            expP = mBusy ? d[mSel] : 1'b0;
            checks++; if (p !== expP) begin errors++; $display("[TB] FAIL rnd_p_comb c%0d: got %b expected %b", c, p, expP); end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_early_release();
        test_datapath();
        test_enable();
        test_reset_mid_grant();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
